// File: rtl/hazard_pkg.sv
// Shared constants and helpers for the ID-stage hazard scoreboard.
// Producer kinds, default widths and the per-kind latency function.
package hazard_pkg;

    localparam logic [1:0] KIND_ALU  = 2'd0;
    localparam logic [1:0] KIND_LOAD = 2'd1;
    localparam logic [1:0] KIND_MDU  = 2'd2;
    localparam logic [1:0] KIND_RSV  = 2'd3;

    localparam int ADDR_W_DEF = 5;
    localparam int CNT_W_DEF  = 3;

    // Cycles until a producer of this kind becomes forwardable.
    function automatic int unsigned lat_of(
        input logic [1:0]  kind,
        input int unsigned load_lat,
        input int unsigned mdu_lat
    );
        int unsigned lat;
        lat = 0;
        case (kind)
            KIND_LOAD: lat = load_lat;
            KIND_MDU:  lat = mdu_lat;
            default:   lat = 0;
        endcase
        return lat;
    endfunction

endpackage

// File: rtl/hazard_lat_cnt.sv
// One latency countdown: load, decrement-if-nonzero, hold.
// Asynchronously cleared; load wins over the same-cycle decrement.
module hazard_lat_cnt
    import hazard_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] cnt
);

    // Count down toward zero while the pipe advances; never wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (en) begin
            if (load) begin
                cnt <= load_val;
            end else if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard unit with a per-register countdown scoreboard.
// Stalls on RAW, WAW and MDU occupancy; honours flush and mem_wait.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int LOAD_LAT = 1,
    parameter int MDU_LAT  = 4,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_id,
    input  logic [ADDR_W-1:0] rs_addr_id,
    input  logic [ADDR_W-1:0] rt_addr_id,
    input  logic              rs_used_id,
    input  logic              rt_used_id,
    input  logic              wr_en_id,
    input  logic [ADDR_W-1:0] wr_addr_id,
    input  logic [1:0]        wr_kind_id,
    input  logic              flush,
    input  logic              mem_wait,
    output logic              stall,
    output logic              pc_if_write,
    output logic              id_ex_bubble,
    output logic              mdu_busy
);

    localparam int NREGS = 2 ** ADDR_W;

    logic [CNT_W-1:0] cnt [NREGS];
    logic [CNT_W-1:0] mdu_cnt;
    logic [CNT_W-1:0] rs_cnt;
    logic [CNT_W-1:0] rt_cnt;
    logic [CNT_W-1:0] wr_cnt;
    logic [CNT_W-1:0] lat_new;
    logic [CNT_W-1:0] mdu_lat_v;
    logic             raw_s;
    logic             raw_t;
    logic             waw;
    logic             mdu_struct;
    logic             is_mdu;
    logic             issue;
    logic             rec_en;
    logic             adv;

    // r0 is hardwired free.
    assign cnt[0] = '0;

    assign adv       = ~mem_wait;
    assign lat_new   = CNT_W'(lat_of(wr_kind_id, LOAD_LAT, MDU_LAT));
    assign mdu_lat_v = CNT_W'(MDU_LAT);
    assign is_mdu    = (wr_kind_id == KIND_MDU);

    generate
        for (genvar r = 1; r < NREGS; r++) begin : g_reg
            hazard_lat_cnt #(.CNT_W(CNT_W)) u_cnt (
                .clk      (clk),
                .rst_n    (rst_n),
                .en       (adv),
                .load     (rec_en && (wr_addr_id == ADDR_W'(r))),
                .load_val (lat_new),
                .cnt      (cnt[r])
            );
        end
    endgenerate

    hazard_lat_cnt #(.CNT_W(CNT_W)) u_mdu_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (adv),
        .load     (issue && is_mdu),
        .load_val (mdu_lat_v),
        .cnt      (mdu_cnt)
    );

    assign rs_cnt = cnt[rs_addr_id];
    assign rt_cnt = cnt[rt_addr_id];
    assign wr_cnt = cnt[wr_addr_id];

    // Hazard detection and pipeline control from scoreboard state.
    always_comb begin
        raw_s      = 1'b0;
        raw_t      = 1'b0;
        waw        = 1'b0;
        mdu_struct = 1'b0;
        if (valid_id) begin
            raw_s = rs_used_id && (rs_addr_id != '0)
                    && (rs_cnt != '0);
            raw_t = rt_used_id && (rt_addr_id != '0)
                    && (rt_cnt != '0);
            waw   = wr_en_id && (wr_addr_id != '0)
                    && (wr_cnt > lat_new);
            mdu_struct = is_mdu && (mdu_cnt > CNT_W'(1));
        end
        stall        = raw_s | raw_t | waw | mdu_struct;
        pc_if_write  = ~(stall | mem_wait);
        id_ex_bubble = flush | (stall & ~mem_wait);
        issue        = valid_id & ~stall & ~mem_wait & ~flush;
        rec_en       = issue & wr_en_id & (wr_addr_id != '0);
    end

    assign mdu_busy = (mdu_cnt != '0);

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard.
// Reference model tracks per-register ready times on a frozen-able clock.
module tb_hazard_scoreboard;

    localparam int LOAD_LAT = 1;
    localparam int MDU_LAT  = 4;

    typedef struct packed {
        logic stall;
        logic pc_if_write;
        logic id_ex_bubble;
        logic mdu_busy;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       valid_id;
    logic [4:0] rs_addr_id;
    logic [4:0] rt_addr_id;
    logic       rs_used_id;
    logic       rt_used_id;
    logic       wr_en_id;
    logic [4:0] wr_addr_id;
    logic [1:0] wr_kind_id;
    logic       flush;
    logic       mem_wait;
    logic       stall;
    logic       pc_if_write;
    logic       id_ex_bubble;
    logic       mdu_busy;

    int checks;
    int fails;

    exp_t exp_q[$];

    // Model: absolute "active tick" at which each result is forwardable.
    int unsigned tick;
    int unsigned ready [32];
    int unsigned mdu_ready;

    hazard_scoreboard #(
        .ADDR_W   (5),
        .LOAD_LAT (LOAD_LAT),
        .MDU_LAT  (MDU_LAT),
        .CNT_W    (3)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .valid_id     (valid_id),
        .rs_addr_id   (rs_addr_id),
        .rt_addr_id   (rt_addr_id),
        .rs_used_id   (rs_used_id),
        .rt_used_id   (rt_used_id),
        .wr_en_id     (wr_en_id),
        .wr_addr_id   (wr_addr_id),
        .wr_kind_id   (wr_kind_id),
        .flush        (flush),
        .mem_wait     (mem_wait),
        .stall        (stall),
        .pc_if_write  (pc_if_write),
        .id_ex_bubble (id_ex_bubble),
        .mdu_busy     (mdu_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int unsigned kind_lat(input logic [1:0] k);
        if (k == 2'd1) return LOAD_LAT;
        if (k == 2'd2) return MDU_LAT;
        return 0;
    endfunction

    function automatic int unsigned remain(input int unsigned t);
        return (t > tick) ? t - tick : 0;
    endfunction

    function automatic void model_clear();
        tick = 0;
        mdu_ready = 0;
        for (int i = 0; i < 32; i++) ready[i] = 0;
    endfunction

    function automatic logic model_stall();
        logic rs_h, rt_h, ww, st;
        rs_h = rs_used_id && rs_addr_id != 0
               && remain(ready[rs_addr_id]) > 0;
        rt_h = rt_used_id && rt_addr_id != 0
               && remain(ready[rt_addr_id]) > 0;
        ww   = wr_en_id && wr_addr_id != 0
               && remain(ready[wr_addr_id]) > kind_lat(wr_kind_id);
        st   = wr_kind_id == 2'd2 && remain(mdu_ready) > 1;
        return valid_id && (rs_h || rt_h || ww || st);
    endfunction

    // Apply stimulus for one cycle; expectation goes to the scoreboard.
    task automatic drive(
        input logic       v,
        input logic [4:0] rs,
        input logic       rsu,
        input logic [4:0] rt,
        input logic       rtu,
        input logic       we,
        input logic [4:0] wa,
        input logic [1:0] kd,
        input logic       fl,
        input logic       mw
    );
        exp_t e;
        logic s;
        valid_id   = v;
        rs_addr_id = rs;
        rs_used_id = rsu;
        rt_addr_id = rt;
        rt_used_id = rtu;
        wr_en_id   = we;
        wr_addr_id = wa;
        wr_kind_id = kd;
        flush      = fl;
        mem_wait   = mw;
        if (!rst_n) model_clear();
        s = model_stall();
        e.stall        = s;
        e.pc_if_write  = !(s || mw);
        e.id_ex_bubble = fl || (s && !mw);
        e.mdu_busy     = remain(mdu_ready) != 0;
        exp_q.push_back(e);
        @(posedge clk);
        if (rst_n && !mw) begin
            tick = tick + 1;
            if (v && !s && !fl) begin
                if (we && wa != 0) ready[wa] = tick + kind_lat(kd);
                if (kd == 2'd2) mdu_ready = tick + MDU_LAT;
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic chk(input string nm, input logic a, input logic r);
        checks++;
        if (a !== r) begin
            fails++;
            $display("FAIL %s actual=%0b required=%0b t=%0t",
                     nm, a, r, $time);
        end
    endtask

    // Monitor: compare DUT outputs mid-cycle against queued expectations.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                chk("stall", stall, e.stall);
                chk("pc_if_write", pc_if_write, e.pc_if_write);
                chk("id_ex_bubble", id_ex_bubble, e.id_ex_bubble);
                chk("mdu_busy", mdu_busy, e.mdu_busy);
            end
        end
    end

    initial begin
        checks = 0;
        fails  = 0;
        model_clear();
        rst_n = 1'b0;
        valid_id = 0; rs_addr_id = 0; rt_addr_id = 0;
        rs_used_id = 0; rt_used_id = 0; wr_en_id = 0;
        wr_addr_id = 0; wr_kind_id = 0; flush = 0; mem_wait = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);

        // Load-use on rs.
        drive(1, 1, 1, 2, 1, 1, 5, 1, 0, 0);
        drive(1, 5, 1, 0, 0, 1, 6, 0, 0, 0);
        drive(1, 5, 1, 0, 0, 1, 6, 0, 0, 0);
        idle(2);

        // MDU r7 then dependent rt read; back-to-back MDU.
        drive(1, 0, 0, 0, 0, 1, 7, 2, 0, 0);
        for (int i = 0; i < 5; i++)
            drive(1, 1, 1, 7, 1, 1, 8, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 1, 9, 2, 0, 0);
        for (int i = 0; i < 4; i++)
            drive(1, 0, 0, 0, 0, 1, 10, 2, 0, 0);
        idle(5);

        // mem_wait freezes a pending load.
        drive(1, 0, 0, 0, 0, 1, 5, 1, 0, 0);
        for (int i = 0; i < 3; i++)
            drive(1, 5, 1, 0, 0, 0, 0, 0, 0, 1);
        drive(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
        idle(2);

        // Flushed load leaves no record.
        drive(1, 0, 0, 0, 0, 1, 9, 1, 1, 0);
        drive(1, 9, 1, 9, 1, 0, 0, 0, 0, 0);
        idle(2);

        // r0 never tracked; rs==rt pending; WAW behind MDU.
        drive(1, 0, 0, 0, 0, 1, 0, 1, 0, 0);
        drive(1, 0, 1, 0, 1, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 1, 4, 1, 0, 0);
        drive(1, 4, 1, 4, 1, 1, 4, 0, 0, 0);
        drive(1, 4, 1, 4, 1, 1, 4, 0, 0, 0);
        idle(5);
        drive(1, 0, 0, 0, 0, 1, 3, 2, 0, 0);
        for (int i = 0; i < 5; i++)
            drive(1, 0, 0, 0, 0, 1, 3, 0, 0, 0);
        idle(5);

        // Async reset mid MDU countdown.
        drive(1, 0, 0, 0, 0, 1, 7, 2, 0, 0);
        drive(1, 7, 1, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        drive(1, 7, 1, 7, 1, 0, 0, 2, 0, 0);
        rst_n = 1'b1;
        drive(1, 7, 1, 7, 1, 0, 0, 2, 0, 0);
        idle(2);

        // Randomized traffic on a small register window.
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(9, 0) != 0,
                  5'($urandom_range(7, 0)), 1'($urandom),
                  5'($urandom_range(7, 0)), 1'($urandom),
                  1'($urandom_range(3, 0) != 0),
                  5'($urandom_range(7, 0)),
                  2'($urandom_range(3, 0)),
                  $urandom_range(9, 0) == 0,
                  $urandom_range(6, 0) == 0);
        end
        idle(1);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++)
            @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain actual=%0d required=0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
